// File: rtl/pc_fleet_responder.sv
`default_nettype none
// ============================================================================
// Module   : pc_fleet_responder
// Brief    : Computer fleet placement (LFSR driven) and shot responder.
//            Optional macro PC_FLEET_REVEAL_EN adds a combinational cell probe.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fleet_responder #(
    parameter int         GRID_N    = 5,
    parameter int         MAX_SHIPS = 5,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
`ifdef PC_FLEET_REVEAL_EN
    input  logic [2:0] dbg_i,
    input  logic [2:0] dbg_j,
    output logic [1:0] dbg_cell,
`endif
    input  logic       place_start,
    input  logic [2:0] pc_ship_count,
    output logic       place_done,
    input  logic       shot_valid,
    input  logic [2:0] shot_i,
    input  logic [2:0] shot_j,
    output logic       shot_ready,
    output logic       resp_valid,
    output logic       resp_hit,
    output logic       resp_repeat,
    output logic       resp_invalid,
    output logic [2:0] ships_left,
    output logic       all_sunk
);

    localparam int         c_cap_int = (MAX_SHIPS < GRID_N * GRID_N) ? MAX_SHIPS : GRID_N * GRID_N;
    localparam logic [2:0] c_cap     = 3'(c_cap_int);
    localparam logic [3:0] c_grid    = 4'(GRID_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLACE = 2'd1,
        S_READY = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_lfsr;
    logic [7:0]  w_lfsr_next;
    // Boards are addressed as {row, col} on a fixed 8x8 map; cells outside GRID_N never set.
    logic [63:0] r_ship;
    logic [63:0] r_shot;
    logic [2:0]  r_target;
    logic [2:0]  r_placed;
    logic [2:0]  r_ships_left;
    logic        r_place_done;
    logic        r_all_sunk;
    logic        r_resp_valid;
    logic        r_resp_hit;
    logic        r_resp_repeat;
    logic        r_resp_invalid;

    logic [2:0]  w_target;
    logic [5:0]  w_cand_idx;
    logic        w_cand_ok;
    logic        w_fill_done;
    logic [5:0]  w_shot_idx;
    logic        w_shot_in_range;
    logic        w_accept;

    assign w_lfsr_next     = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
    assign w_target        = (pc_ship_count > c_cap) ? c_cap : pc_ship_count;
    assign w_cand_idx      = {r_lfsr[2:0], r_lfsr[5:3]};
    assign w_cand_ok       = ({1'b0, r_lfsr[2:0]} < c_grid) && ({1'b0, r_lfsr[5:3]} < c_grid)
                             && !r_ship[w_cand_idx];
    assign w_fill_done     = (r_placed == r_target);
    assign w_shot_idx      = {shot_i, shot_j};
    assign w_shot_in_range = ({1'b0, shot_i} < c_grid) && ({1'b0, shot_j} < c_grid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        shot_ready   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (place_start) w_state_next = S_PLACE;
            end
            S_PLACE: begin
                if (place_start)      w_state_next = S_PLACE;
                else if (w_fill_done) w_state_next = S_READY;
            end
            S_READY: begin
                shot_ready = 1'b1;
                if (place_start) begin
                    w_state_next = S_PLACE;
                end else if (shot_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = place_start ? S_PLACE : S_READY;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The shot is classified at acceptance so ships_left/all_sunk already reflect it
    // during the response cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr         <= LFSR_SEED;
            r_ship         <= '0;
            r_shot         <= '0;
            r_target       <= '0;
            r_placed       <= '0;
            r_ships_left   <= '0;
            r_place_done   <= 1'b0;
            r_all_sunk     <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_hit     <= 1'b0;
            r_resp_repeat  <= 1'b0;
            r_resp_invalid <= 1'b0;
        end else begin
            r_lfsr         <= w_lfsr_next;
            r_resp_valid   <= 1'b0;
            r_resp_hit     <= 1'b0;
            r_resp_repeat  <= 1'b0;
            r_resp_invalid <= 1'b0;
            if (place_start) begin
                r_ship       <= '0;
                r_shot       <= '0;
                r_target     <= w_target;
                r_placed     <= '0;
                r_ships_left <= '0;
                r_place_done <= 1'b0;
                r_all_sunk   <= 1'b0;
            end else if (r_state == S_PLACE) begin
                if (w_fill_done) begin
                    r_ships_left <= r_target;
                    r_place_done <= 1'b1;
                    r_all_sunk   <= (r_target == 3'd0);
                end else if (w_cand_ok) begin
                    r_ship[w_cand_idx] <= 1'b1;
                    r_placed           <= r_placed + 3'd1;
                end
            end else if (w_accept) begin
                r_resp_valid <= 1'b1;
                if (!w_shot_in_range) begin
                    r_resp_invalid <= 1'b1;
                end else if (r_shot[w_shot_idx]) begin
                    r_resp_repeat <= 1'b1;
                end else begin
                    r_shot[w_shot_idx] <= 1'b1;
                    if (r_ship[w_shot_idx]) begin
                        r_resp_hit   <= 1'b1;
                        r_ships_left <= r_ships_left - 3'd1;
                        r_all_sunk   <= (r_ships_left == 3'd1);
                    end
                end
            end
        end
    end

    // A place_start during the response cycle drops the pending response.
    assign resp_valid   = r_resp_valid   & ~place_start;
    assign resp_hit     = r_resp_hit     & ~place_start;
    assign resp_repeat  = r_resp_repeat  & ~place_start;
    assign resp_invalid = r_resp_invalid & ~place_start;
    assign place_done   = r_place_done;
    assign ships_left   = r_ships_left;
    assign all_sunk     = r_all_sunk;

`ifdef PC_FLEET_REVEAL_EN
    logic [5:0] w_dbg_idx;
    assign w_dbg_idx = {dbg_i, dbg_j};
    assign dbg_cell  = (({1'b0, dbg_i} < c_grid) && ({1'b0, dbg_j} < c_grid))
                       ? {r_shot[w_dbg_idx], r_ship[w_dbg_idx]} : 2'b00;
`endif

endmodule
`default_nettype wire
